// File: rtl/cordic_uv_ctrl_pkg.sv
// Shared types for the UV CORDIC sequencer: FSM state encoding and operating-mode constants.
package cordic_uv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StVec  = 3'd1,
    StGap  = 3'd2,
    StRot  = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic MODE_VEC_ROT  = 1'b0;
  localparam logic MODE_ROT_ONLY = 1'b1;

  // States in which the iteration counter drives shift/count/sel.
  function automatic logic is_iter_state(state_e s);
    return (s == StVec) || (s == StRot);
  endfunction

endpackage

// File: rtl/cordic_sign_mem.sv
// N_ITER-bit store of micro-rotation directions recorded while vectoring and replayed while rotating.
module cordic_sign_mem #(
  parameter int unsigned N_ITER     = 16,
  parameter int unsigned WIDTH_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WIDTH_ADDR-1:0] waddr,
  input  logic                  wdata,
  input  logic [WIDTH_ADDR-1:0] raddr,
  output logic                  rdata
);

  logic [N_ITER-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cordic_uv_ctrl.sv
// Sequencer for the 2x8 UV CORDIC array: vectoring on the pivot column, then rotation of all
// columns by replaying the recorded directions (or replay only, for the U/V update).
module cordic_uv_ctrl
  import cordic_uv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_SHIFT_BIT = 4,
  parameter int unsigned WIDTH_INDEX     = 3,
  parameter int unsigned N_ITER          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [WIDTH_INDEX-1:0]     index_in,
  input  logic                       x_neg,
  input  logic [7:0]                 y_sign,
  output logic                       ce0,
  output logic                       ce1,
  output logic                       sel,
  output logic [WIDTH_SHIFT_BIT-1:0] shift,
  output logic [WIDTH_SHIFT_BIT-1:0] count,
  output logic                       sign_rotation,
  output logic                       sign_in,
  output logic [WIDTH_INDEX-1:0]     index,
  output logic                       busy,
  output logic                       done
);

  localparam logic [WIDTH_SHIFT_BIT-1:0] LastIter = WIDTH_SHIFT_BIT'(N_ITER - 1);

  state_e                     state_q, state_d;
  logic [WIDTH_SHIFT_BIT-1:0] iter_q, iter_d;
  logic [WIDTH_INDEX-1:0]     index_d;
  logic                       sign_in_d;
  logic                       vec_sign;
  logic                       mem_rdata;
  logic                       rot_sign_q;

  assign vec_sign = y_sign[index];

  cordic_sign_mem #(
    .N_ITER     (N_ITER),
    .WIDTH_ADDR (WIDTH_SHIFT_BIT)
  ) u_sign_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (state_q == StVec),
    .waddr (iter_q),
    .wdata (vec_sign),
    .raddr (iter_d),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    index_d   = index;
    sign_in_d = sign_in;
    case (state_q)
      StIdle: begin
        if (start) begin
          index_d   = index_in;
          sign_in_d = x_neg;
          iter_d    = '0;
          state_d   = (mode == MODE_ROT_ONLY) ? StRot : StVec;
        end
      end
      StVec: begin
        if (iter_q == LastIter) begin
          state_d = StGap;
          iter_d  = '0;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StRot;
        iter_d  = '0;
      end
      StRot: begin
        if (iter_q == LastIter) begin
          state_d = StDone;
          iter_d  = '0;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      index      <= '0;
      sign_in    <= 1'b0;
      ce0        <= 1'b0;
      ce1        <= 1'b0;
      sel        <= 1'b0;
      shift      <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rot_sign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      index      <= index_d;
      sign_in    <= sign_in_d;
      ce0        <= (state_d == StRot) || ((state_d == StVec) && !index_d[WIDTH_INDEX-1]);
      ce1        <= (state_d == StRot) || ((state_d == StVec) && index_d[WIDTH_INDEX-1]);
      sel        <= is_iter_state(state_d) && (iter_d != '0);
      shift      <= is_iter_state(state_d) ? iter_d : '0;
      count      <= is_iter_state(state_d) ? (LastIter - iter_d) : '0;
      busy       <= (state_d != StIdle);
      done       <= (state_d == StDone);
      rot_sign_q <= (state_d == StRot) && mem_rdata;
    end
  end

  // Vectoring must follow the pivot's y sign in the same cycle.
  assign sign_rotation = (state_q == StVec) ? vec_sign : rot_sign_q;

endmodule

// File: tb/tb_cordic_uv_ctrl.sv
// Scoreboard bench for cordic_uv_ctrl: stimulus queues expected per-cycle outputs, monitor checks.
module tb_cordic_uv_ctrl;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, start, mode, x_neg;
  logic [2:0] index_in;
  logic [7:0] y_sign;
  logic       ce0, ce1, sel, sign_rotation, sign_in, busy, done;
  logic [3:0] shift, count;
  logic [2:0] index;

  typedef struct packed {
    logic       ce0;
    logic       ce1;
    logic       sel;
    logic [3:0] shift;
    logic [3:0] count;
    logic       sr;
    logic       sign_in;
    logic [2:0] index;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] model = '0;
  out_t        act;

  assign act = {ce0, ce1, sel, shift, count, sign_rotation, sign_in, index, busy, done};

  cordic_uv_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .index_in      (index_in),
    .x_neg         (x_neg),
    .y_sign        (y_sign),
    .ce0           (ce0),
    .ce1           (ce1),
    .sel           (sel),
    .shift         (shift),
    .count         (count),
    .sign_rotation (sign_rotation),
    .sign_in       (sign_in),
    .index         (index),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic out_t mk(input logic c0, input logic c1, input logic s, input int sh,
                              input logic sr, input logic si, input logic [2:0] ix,
                              input logic b, input logic d);
    out_t o;
    o.ce0     = c0;
    o.ce1     = c1;
    o.sel     = s;
    o.shift   = 4'(sh);
    o.count   = (b && !d && (c0 || c1)) ? 4'(N - 1 - sh) : 4'd0;
    o.sr      = sr;
    o.sign_in = si;
    o.index   = ix;
    o.busy    = b;
    o.done    = d;
    return o;
  endfunction

  // Monitor: every cycle the DUT is busy or done must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (busy || done)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got %h with nothing expected (cycle %0d)", act, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cycle", cyc, e.cyc);
        check("outputs", 32'(act), 32'(e.o));
      end
    end
  end

  // One operation; ign pulses stray starts in VEC iteration 3 and in DONE,
  // abort_rot >= 0 asserts rst at that ROT iteration.
  task automatic run(input logic m, input logic [2:0] idx, input logic xn, input logic [15:0] pat,
                     input bit ign, input int abort_rot);
    int          c0, nvec, base, total;
    logic [15:0] rexp;
    @(posedge clk);
    #1;
    c0   = cyc;
    rexp = m ? model : pat;
    nvec = m ? 0 : N;
    for (int i = 0; i < nvec; i++)
      sb.push_back('{c0 + 1 + i, mk(~idx[2], idx[2], i != 0, i, pat[i], xn, idx, 1'b1, 1'b0)});
    if (!m) sb.push_back('{c0 + N + 1, mk(1'b0, 1'b0, 1'b0, 0, 1'b0, xn, idx, 1'b1, 1'b0)});
    base = c0 + 1 + (m ? 0 : N + 1);
    for (int i = 0; i < N; i++)
      if (abort_rot < 0 || i < abort_rot)
        sb.push_back('{base + i, mk(1'b1, 1'b1, i != 0, i, rexp[i], xn, idx, 1'b1, 1'b0)});
    if (abort_rot < 0) sb.push_back('{base + N, mk(1'b0, 1'b0, 1'b0, 0, 1'b0, xn, idx, 1'b1, 1'b1)});
    if (!m) model = pat;
    total = base + N - c0 - 1;

    start = 1'b1; mode = m; index_in = idx; x_neg = xn;
    @(posedge clk);
    #1;
    start = 1'b0; mode = 1'($urandom); index_in = 3'($urandom); x_neg = 1'($urandom);
    for (int k = 0; k < total; k++) begin
      y_sign = 8'($urandom);
      if (k < nvec) y_sign[idx] = pat[k];
      if (abort_rot >= 0 && cyc == base + abort_rot) begin
        rst = 1'b1;
        #1;
        check("reset_mid_rot", 32'(act), 32'd0);
        model = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("queue_after_abort", sb.size(), 0);
        return;
      end
      if (ign && k == 3) begin
        start = 1'b1; mode = 1'b1; index_in = ~idx; x_neg = ~xn;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (ign) begin
      start = 1'b1; mode = 1'b0; index_in = ~idx; x_neg = ~xn;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", sb.size(), 0);
    check("index_held", 32'(index), 32'(idx));
    check("sign_in_held", 32'(sign_in), 32'(xn));
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; index_in = '0; x_neg = 1'b0; y_sign = '0;
    #2;
    check("reset_initial", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      y_sign = 8'($urandom); index_in = 3'($urandom); x_neg = 1'($urandom); mode = 1'($urandom);
    end
    rst = 1'b1;
    #1;
    check("reset_after_toggle", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(1'b0, 3'd2, 1'b1, 16'hA5C3, 1'b0, -1);
    run(1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, -1);
    run(1'b0, 3'd5, 1'b0, 16'h3C96, 1'b0, -1);
    run(1'b0, 3'd1, 1'b1, 16'h5A0F, 1'b1, -1);

    rst = 1'b1;
    #1;
    check("reset_idle_clears_index", 32'(act), 32'd0);
    model = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(1'b0, 3'd6, 1'b1, 16'hFFFF, 1'b0, 5);
    run(1'b1, 3'd3, 1'b1, 16'h0000, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
